// File: rtl/patgen_multi.sv
// patgen_multi: colour-bar / scrolling-bar / gray-ramp / checkerboard test pattern
// generator with a fixed 2-cycle pipeline from input syncs to display outputs.
`default_nettype none

module patgen_multi #(
  parameter int CW       = 8,
  parameter int XW       = 11,
  parameter int YW       = 11,
  parameter int CHK_LOG2 = 5,
  parameter int RAMP_SH  = 2
) (
  input  logic          DCLK,
  input  logic          ARESETN,
  input  logic [1:0]    MODE,
  input  logic [XW-1:0] BAR_W,
  input  logic          SCROLL_EN,
  input  logic [7:0]    SCROLL_DIV,
  input  logic          IN_HSYNC_X,
  input  logic          IN_VSYNC_X,
  input  logic          IN_DE,
  output logic          DSP_HSYNC_X,
  output logic          DSP_VSYNC_X,
  output logic          DSP_DE,
  output logic [CW-1:0] DSP_R,
  output logic [CW-1:0] DSP_G,
  output logic [CW-1:0] DSP_B
);

  logic          vs_prev, de_prev;
  logic [1:0]    mode_l;
  logic [XW-1:0] bar_w_l;
  logic          scroll_en_l;
  logic [7:0]    scroll_div_l;
  logic [2:0]    phase;
  logic [7:0]    div_cnt;
  logic [XW-1:0] x_next, run_next;
  logic [2:0]    bar_next;
  logic [YW-1:0] y;
  logic          hs1, vs1, de1;
  logic [CW-1:0] r1, g1, b1;

  logic          frame_start, line_first, run_last, chk;
  logic [XW-1:0] cur_x, cur_run, eff_w;
  logic [2:0]    cur_bar, start_bar;
  logic [CW-1:0] pix_r, pix_g, pix_b, gray;

  localparam logic [CW-1:0] FULL = {CW{1'b1}};

  // Counters hold the state for the *next* DE pixel; the first pixel of a line
  // restarts them so no line-start event needs to be tracked separately.
  assign frame_start = vs_prev & ~IN_VSYNC_X;
  assign line_first  = ~de_prev;
  assign start_bar   = (mode_l == 2'd1) ? phase : 3'd0;
  assign cur_x       = line_first ? '0 : x_next;
  assign cur_run     = line_first ? '0 : run_next;
  assign cur_bar     = line_first ? start_bar : bar_next;
  assign eff_w       = (bar_w_l == '0) ? XW'(1) : bar_w_l;
  assign run_last    = (cur_run == eff_w - XW'(1));
  assign gray        = CW'(cur_x >> RAMP_SH);
  assign chk         = cur_x[CHK_LOG2] ^ y[CHK_LOG2];

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode_l)
      2'd2: begin
        pix_r = gray;
        pix_g = gray;
        pix_b = gray;
      end
      2'd3: begin
        pix_r = chk ? FULL : '0;
        pix_g = chk ? FULL : '0;
        pix_b = chk ? FULL : '0;
      end
      default: begin
        pix_r = cur_bar[1] ? '0 : FULL;
        pix_g = cur_bar[2] ? '0 : FULL;
        pix_b = cur_bar[0] ? '0 : FULL;
      end
    endcase
  end

  always_ff @(posedge DCLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vs_prev      <= 1'b0;
      de_prev      <= 1'b0;
      mode_l       <= '0;
      bar_w_l      <= '0;
      scroll_en_l  <= 1'b0;
      scroll_div_l <= '0;
      phase        <= '0;
      div_cnt      <= '0;
      x_next       <= '0;
      run_next     <= '0;
      bar_next     <= '0;
      y            <= '0;
      hs1          <= 1'b1;
      vs1          <= 1'b1;
      de1          <= 1'b0;
      r1           <= '0;
      g1           <= '0;
      b1           <= '0;
      DSP_HSYNC_X  <= 1'b1;
      DSP_VSYNC_X  <= 1'b1;
      DSP_DE       <= 1'b0;
      DSP_R        <= '0;
      DSP_G        <= '0;
      DSP_B        <= '0;
    end else begin
      vs_prev <= IN_VSYNC_X;
      de_prev <= IN_DE;

      if (IN_DE) begin
        x_next <= cur_x + XW'(1);
        if (run_last) begin
          run_next <= '0;
          bar_next <= cur_bar + 3'd1;
        end else begin
          run_next <= cur_run + XW'(1);
          bar_next <= cur_bar;
        end
      end

      if (frame_start)
        y <= '0;
      else if (de_prev && !IN_DE)
        y <= y + YW'(1);

      // Scroll bookkeeping uses the settings latched for the frame just ending.
      if (frame_start) begin
        mode_l       <= MODE;
        bar_w_l      <= BAR_W;
        scroll_en_l  <= SCROLL_EN;
        scroll_div_l <= SCROLL_DIV;
        if (scroll_en_l) begin
          if (div_cnt == scroll_div_l) begin
            phase   <= phase + 3'd1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end else begin
          div_cnt <= '0;
        end
      end

      hs1 <= IN_HSYNC_X;
      vs1 <= IN_VSYNC_X;
      de1 <= IN_DE;
      r1  <= IN_DE ? pix_r : '0;
      g1  <= IN_DE ? pix_g : '0;
      b1  <= IN_DE ? pix_b : '0;

      DSP_HSYNC_X <= hs1;
      DSP_VSYNC_X <= vs1;
      DSP_DE      <= de1;
      DSP_R       <= r1;
      DSP_G       <= g1;
      DSP_B       <= b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_patgen_multi.sv
// tb_patgen_multi: directed-vector bench; every driven cycle is compared two
// cycles later against the expected sync/DE/colour word.
`default_nettype none

module tb_patgen_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [10:0] bar_w;
  logic        scroll_en;
  logic [7:0]  scroll_div;
  logic        hs_in, vs_in, de_in;
  logic        hs_out, vs_out, de_out;
  logic [7:0]  r_out, g_out, b_out;

  int n_vec = 0;
  int n_err = 0;
  string tag = "reset";
  logic [26:0] pipe1, pipe2;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h0};

  patgen_multi dut (
    .DCLK(clk), .ARESETN(rst_n), .MODE(mode), .BAR_W(bar_w),
    .SCROLL_EN(scroll_en), .SCROLL_DIV(scroll_div),
    .IN_HSYNC_X(hs_in), .IN_VSYNC_X(vs_in), .IN_DE(de_in),
    .DSP_HSYNC_X(hs_out), .DSP_VSYNC_X(vs_out), .DSP_DE(de_out),
    .DSP_R(r_out), .DSP_G(g_out), .DSP_B(b_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string t, input logic [26:0] got, input logic [26:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input int m, input int w, input int ph,
                                          input int x, input int yv);
    int weff;
    int g;
    weff = (w == 0) ? 1 : w;
    case (m)
      0: return bar_rgb((x / weff) % 8);
      1: return bar_rgb(((x / weff) + ph) % 8);
      2: begin
        g = (x >> 2) & 255;
        return {g[7:0], g[7:0], g[7:0]};
      end
      default: return ((((x >> 5) ^ (yv >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Drive one cycle; the word driven two ticks ago must now be on the outputs.
  task automatic tick(input logic hs, input logic vs, input logic de, input logic [23:0] rgb);
    @(negedge clk);
    check_val(tag, {hs_out, vs_out, de_out, r_out, g_out, b_out}, pipe2);
    pipe2 = pipe1;
    pipe1 = {hs, vs, de, de ? rgb : 24'h0};
    hs_in = hs;
    vs_in = vs;
    de_in = de;
  endtask

  task automatic vs_start();
    repeat (2) tick(1'b1, 1'b0, 1'b0, 24'h0);
    repeat (2) tick(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic line(input int npix, input int m, input int w, input int ph, input int yv);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (2) tick(1'b1, 1'b1, 1'b0, 24'h0);
    for (int x = 0; x < npix; x++)
      tick(1'b1, 1'b1, 1'b1, exp_pix(m, w, ph, x, yv));
    repeat (2) tick(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  int ph_tab[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    rst_n = 1'b1;
    mode = 2'd0; bar_w = 11'd0; scroll_en = 1'b0; scroll_div = 8'd0;
    hs_in = 1'b0; vs_in = 1'b1; de_in = 1'b1;
    pipe1 = IDLE; pipe2 = IDLE;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_hs", {26'h0, hs_out}, 27'd1);
    check_val("rst_vs", {26'h0, vs_out}, 27'd1);
    check_val("rst_de", {26'h0, de_out}, 27'd0);
    check_val("rst_rgb", {3'b0, r_out, g_out, b_out}, 27'h0);
    hs_in = 1'b1; de_in = 1'b0;
    rst_n = 1'b1;

    tag = "prefrm";
    line(12, 0, 1, 0, 0);

    tag = "latency";
    mode = 2'd0; bar_w = 11'd4;
    vs_start();
    line(40, 0, 4, 0, 0);

    tag = "scroll";
    mode = 2'd1; bar_w = 11'd2; scroll_en = 1'b1; scroll_div = 8'd2;
    for (int f = 0; f < 10; f++) begin
      vs_start();
      line(8, 1, 2, ph_tab[f], 0);
    end

    tag = "midfrm";
    mode = 2'd0; bar_w = 11'd4; scroll_en = 1'b0;
    vs_start();
    line(16, 0, 4, 0, 0);
    mode = 2'd3;
    line(16, 0, 4, 0, 1);
    tag = "checker";
    vs_start();
    for (int yv = 0; yv < 34; yv++)
      line(64, 3, 0, 0, yv);

    tag = "ramp";
    mode = 2'd2;
    vs_start();
    line(1028, 2, 0, 0, 0);

    tag = "barw0";
    mode = 2'd0; bar_w = 11'd0;
    vs_start();
    line(10, 0, 0, 0, 0);

    tag = "rstmid";
    bar_w = 11'd8;
    vs_start();
    repeat (2) tick(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (2) tick(1'b1, 1'b1, 1'b0, 24'h0);
    for (int x = 0; x < 4; x++)
      tick(1'b1, 1'b1, 1'b1, exp_pix(0, 8, 0, x, 0));
    #2;
    check_val("pre_rst", {2'b0, de_out, r_out, g_out, b_out}, {2'b0, 1'b1, 24'hFFFFFF});
    rst_n = 1'b0;
    #1;
    check_val("async_rst", {hs_out, vs_out, de_out, r_out, g_out, b_out}, IDLE);
    de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    mode = 2'd2; bar_w = 11'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pipe1 = IDLE; pipe2 = IDLE;
    tag = "postrst";
    line(8, 0, 1, 0, 0);
    vs_start();
    line(16, 2, 0, 0, 0);
    repeat (3) tick(1'b1, 1'b1, 1'b0, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
